// File: rtl/insn_encoder.sv
// ---------------------------------------------------------------------------
// insn_encoder
//   Program loader / stimulus generator. Turns symbolic instruction commands
//   (mnemonic + register/immediate operands) into 32-bit instruction words in
//   the decoder's field format, buffers them in a small FIFO and writes them
//   sequentially into instruction memory at an auto-incrementing address.
//
//   Field layout: op[31:26] rs[25:21] rt[20:16] rd[15:11] shamt[10:6]
//                 funct[5:0]; constant in [15:0].
//
// Parameters
//   FIFO_DEPTH  encoded-word buffer entries (power of two, >= 2)
//   ADDR_WIDTH  word-address width of the IMem write port
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start, baseAddr   begin a load session at baseAddr (honoured in IDLE only)
//   cmdValid/cmdReady command handshake; cmdLast marks the final command
//   cmdMnem, cmdDst, cmdSrcA, cmdSrcB, cmdShamt, cmdImm   command fields
//   cmdError          (INSN_ENCODER_CHECK_EN only) pulse for a rejected command
//   wrValid/wrReady   IMem write handshake; wrAddr/wrData address and word
//   busy              session active
//   done              one-cycle pulse at end of session
//   insnCount         words written in the current/most recent session
//
// Configuration
//   INSN_ENCODER_CHECK_EN  when defined, illegal mnemonics (14-15) and shift
//   commands with a nonzero cmdSrcB are consumed without being written and
//   flagged on cmdError. When undefined, illegal mnemonics encode as 0.
// ---------------------------------------------------------------------------
module insn_encoder #(
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] baseAddr,
   input  logic                  cmdValid,
   output logic                  cmdReady,
`ifdef INSN_ENCODER_CHECK_EN
   output logic                  cmdError,
`endif
   input  logic                  cmdLast,
   input  logic [3:0]            cmdMnem,
   input  logic [4:0]            cmdDst,
   input  logic [4:0]            cmdSrcA,
   input  logic [4:0]            cmdSrcB,
   input  logic [4:0]            cmdShamt,
   input  logic [15:0]           cmdImm,
   output logic                  wrValid,
   input  logic                  wrReady,
   output logic [ADDR_WIDTH-1:0] wrAddr,
   output logic [31:0]           wrData,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH:0]   insnCount
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PTR_W:0]      FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
   localparam logic [ADDR_WIDTH:0] CNT_MAX  = {1'b1, {ADDR_WIDTH{1'b0}}};

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t           state, stateNext;
   logic [31:0]      mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wrPtr, rdPtr;
   logic [PTR_W:0]   count;
   logic             fifoFull, fifoEmpty;
   logic             cmdAccept, push, pop;
   logic [31:0]      encWord;

   function automatic logic [31:0] encode(
      input logic [3:0]  mnem,
      input logic [4:0]  dst,
      input logic [4:0]  srcA,
      input logic [4:0]  srcB,
      input logic [4:0]  shamt,
      input logic [15:0] imm
   );
      logic [31:0] w;
      case (mnem)
         4'd0:    w = {6'h00, 5'd0, srcA, dst, shamt, 6'h00};   // SLL
         4'd1:    w = {6'h00, 5'd0, srcA, dst, shamt, 6'h02};   // SRL
         4'd2:    w = {6'h00, srcA, srcB, dst, 5'd0, 6'h20};    // ADD
         4'd3:    w = {6'h00, srcA, srcB, dst, 5'd0, 6'h22};    // SUB
         4'd4:    w = {6'h00, srcA, srcB, dst, 5'd0, 6'h24};    // AND
         4'd5:    w = {6'h00, srcA, srcB, dst, 5'd0, 6'h25};    // OR
         4'd6:    w = {6'h00, srcA, srcB, dst, 5'd0, 6'h2A};    // SLT
         4'd7:    w = {6'h08, srcA, dst, imm};                  // ADDI
         4'd8:    w = {6'h0C, srcA, dst, imm};                  // ANDI
         4'd9:    w = {6'h0D, srcA, dst, imm};                  // ORI
         4'd10:   w = {6'h23, srcA, dst, imm};                  // LD
         4'd11:   w = {6'h2B, srcA, srcB, imm};                 // ST
         4'd12:   w = {6'h04, srcA, srcB, imm};                 // BEQ
         4'd13:   w = {6'h05, srcA, srcB, imm};                 // BNE
         default: w = 32'h0000_0000;                            // illegal -> SLL r0,r0,0
      endcase
      return w;
   endfunction

   assign encWord   = encode(cmdMnem, cmdDst, cmdSrcA, cmdSrcB, cmdShamt, cmdImm);
   assign fifoEmpty = (count == '0);
   // Fullness ignores a same-cycle pop so cmdReady never depends on wrReady.
   assign fifoFull  = (count == FULL_CNT);
   assign cmdAccept = cmdValid && cmdReady;
   assign pop       = wrValid && wrReady;

`ifdef INSN_ENCODER_CHECK_EN
   logic cmdIllegal;
   assign cmdIllegal = (cmdMnem >= 4'd14) ||
                       (((cmdMnem == 4'd0) || (cmdMnem == 4'd1)) && (cmdSrcB != 5'd0));
   assign push = cmdAccept && !cmdIllegal;
`else
   assign push = cmdAccept;
`endif

   // Output side: the FIFO head is presented directly; an empty FIFO shows 0.
   assign wrValid = !fifoEmpty;
   assign wrData  = fifoEmpty ? 32'h0000_0000 : mem[rdPtr];

   always_comb begin
      stateNext = state;
      cmdReady  = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) stateNext = RUN;
         end
         RUN: begin
            busy     = 1'b1;
            cmdReady = !fifoFull;
            if (cmdValid && !fifoFull && cmdLast) stateNext = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            // Empty FIFO means no write is outstanding either.
            if (fifoEmpty) stateNext = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         wrPtr     <= '0;
         rdPtr     <= '0;
         count     <= '0;
         wrAddr    <= '0;
         insnCount <= '0;
`ifdef INSN_ENCODER_CHECK_EN
         cmdError  <= 1'b0;
`endif
      end else begin
         state <= stateNext;
         if (push) wrPtr <= wrPtr + 1'b1;
         if (pop)  rdPtr <= rdPtr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if ((state == IDLE) && start) begin
            wrAddr    <= baseAddr;
            insnCount <= '0;
         end else if (pop) begin
            wrAddr <= wrAddr + 1'b1;               // wraps modulo 2^ADDR_WIDTH
            if (insnCount != CNT_MAX) insnCount <= insnCount + 1'b1;
         end
`ifdef INSN_ENCODER_CHECK_EN
         cmdError <= cmdAccept && cmdIllegal;
`endif
      end
   end

   // Word storage carries no reset; the pointers/count define validity.
   always_ff @(posedge clk) begin
      if (push) mem[wrPtr] <= encWord;
   end

endmodule

// File: tb/tb_insn_encoder.sv
// ---------------------------------------------------------------------------
// tb_insn_encoder
//   Self-checking bench for insn_encoder (FIFO_DEPTH=4, ADDR_WIDTH=10).
//   A table of commands with hand-encoded words drives the main session;
//   short hand-written sequences cover latency, backpressure, address wrap,
//   mid-session reset and illegal-command handling.
// ---------------------------------------------------------------------------
module tb_insn_encoder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [9:0]  baseAddr = '0;
   logic        cmdValid = 1'b0;
   logic        cmdReady;
   logic        cmdLast = 1'b0;
   logic [3:0]  cmdMnem = '0;
   logic [4:0]  cmdDst = '0, cmdSrcA = '0, cmdSrcB = '0, cmdShamt = '0;
   logic [15:0] cmdImm = '0;
   logic        wrValid;
   logic        wrReady = 1'b1;
   logic [9:0]  wrAddr;
   logic [31:0] wrData;
   logic        busy, done;
   logic [10:0] insnCount;
`ifdef INSN_ENCODER_CHECK_EN
   logic        cmdError;
   int          errPulses = 0;
`endif

   insn_encoder #(.FIFO_DEPTH(4), .ADDR_WIDTH(10)) dut (
      .clk(clk), .rst(rst), .start(start), .baseAddr(baseAddr),
      .cmdValid(cmdValid), .cmdReady(cmdReady),
`ifdef INSN_ENCODER_CHECK_EN
      .cmdError(cmdError),
`endif
      .cmdLast(cmdLast), .cmdMnem(cmdMnem), .cmdDst(cmdDst),
      .cmdSrcA(cmdSrcA), .cmdSrcB(cmdSrcB), .cmdShamt(cmdShamt), .cmdImm(cmdImm),
      .wrValid(wrValid), .wrReady(wrReady), .wrAddr(wrAddr), .wrData(wrData),
      .busy(busy), .done(done), .insnCount(insnCount)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  mnem;
      logic [4:0]  dst, srcA, srcB, shamt;
      logic [15:0] imm;
      logic [31:0] exp;
   } vec_t;

   vec_t        tbl [14];
   logic [9:0]  gotAddr [$];
   logic [31:0] gotData [$];
   int          nChecks = 0;
   int          nFails  = 0;

   // Record every write handshake; inputs are stable mid-cycle.
   always @(negedge clk) begin
      if (!rst && wrValid && wrReady) begin
         gotAddr.push_back(wrAddr);
         gotData.push_back(wrData);
      end
`ifdef INSN_ENCODER_CHECK_EN
      if (cmdError) errPulses++;
`endif
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic startSession(input logic [9:0] base);
      gotAddr.delete();
      gotData.delete();
      @(posedge clk); #1;
      start = 1'b1; baseAddr = base;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic sendRaw(input logic [3:0] m, input logic [4:0] d, input logic [4:0] a,
                          input logic [4:0] b, input logic [4:0] s, input logic [15:0] imm,
                          input logic last);
      int w = 0;
      @(posedge clk); #1;
      cmdValid = 1'b1; cmdLast = last; cmdMnem = m;
      cmdDst = d; cmdSrcA = a; cmdSrcB = b; cmdShamt = s; cmdImm = imm;
      @(negedge clk);
      while (!cmdReady && w < 100) begin
         @(negedge clk);
         w++;
      end
      chk("cmdAcceptWithinBudget", {31'd0, cmdReady}, 32'd1);
      @(posedge clk); #1;
      cmdValid = 1'b0; cmdLast = 1'b0;
   endtask

   task automatic sendVec(input int i, input logic last);
      sendRaw(tbl[i].mnem, tbl[i].dst, tbl[i].srcA, tbl[i].srcB, tbl[i].shamt, tbl[i].imm, last);
   endtask

   task automatic waitDone(input logic [10:0] expCount);
      int w = 0;
      @(negedge clk);
      while (!done && w < 200) begin
         @(negedge clk);
         w++;
      end
      chk("doneSeen", {31'd0, done}, 32'd1);
      chk("insnCountAtDone", {21'd0, insnCount}, {21'd0, expCount});
      @(negedge clk);
      chk("donePulseOneCycle", {30'd0, done, busy}, 32'd0);
   endtask

   task automatic checkWrite(input int k, input logic [9:0] a, input logic [31:0] d);
      if (k < gotAddr.size()) begin
         chk($sformatf("wrAddr[%0d]", k), {22'd0, gotAddr[k]}, {22'd0, a});
         chk($sformatf("wrData[%0d]", k), gotData[k], d);
      end else begin
         chk($sformatf("writeMissing[%0d]", k), 32'(gotAddr.size()), 32'(k + 1));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //           mnem  dst    srcA   srcB   shamt  imm        expected
      tbl[0]  = '{4'd2,  5'd3,  5'd1,  5'd2,  5'd7,  16'hFFFF, 32'h00221820}; // ADD
      tbl[1]  = '{4'd7,  5'd5,  5'd0,  5'd31, 5'd31, 16'h0007, 32'h20050007}; // ADDI
      tbl[2]  = '{4'd0,  5'd4,  5'd2,  5'd0,  5'd3,  16'hABCD, 32'h000220C0}; // SLL
      tbl[3]  = '{4'd10, 5'd6,  5'd1,  5'd9,  5'd5,  16'h0004, 32'h8C260004}; // LD
      tbl[4]  = '{4'd12, 5'd31, 5'd1,  5'd2,  5'd4,  16'hFFFE, 32'h1022FFFE}; // BEQ
      tbl[5]  = '{4'd1,  5'd7,  5'd8,  5'd0,  5'd31, 16'h0000, 32'h00083FC2}; // SRL
      tbl[6]  = '{4'd3,  5'd1,  5'd2,  5'd3,  5'd0,  16'h0000, 32'h00430822}; // SUB
      tbl[7]  = '{4'd4,  5'd31, 5'd31, 5'd31, 5'd31, 16'hFFFF, 32'h03FFF824}; // AND
      tbl[8]  = '{4'd5,  5'd2,  5'd4,  5'd6,  5'd0,  16'h0000, 32'h00861025}; // OR
      tbl[9]  = '{4'd6,  5'd10, 5'd9,  5'd8,  5'd0,  16'h0000, 32'h0128502A}; // SLT
      tbl[10] = '{4'd8,  5'd3,  5'd5,  5'd0,  5'd0,  16'h00FF, 32'h30A300FF}; // ANDI
      tbl[11] = '{4'd9,  5'd9,  5'd0,  5'd0,  5'd0,  16'h1234, 32'h34091234}; // ORI
      tbl[12] = '{4'd11, 5'd7,  5'd29, 5'd4,  5'd0,  16'h0008, 32'hAFA40008}; // ST
      tbl[13] = '{4'd13, 5'd0,  5'd5,  5'd0,  5'd0,  16'h8000, 32'h14A08000}; // BNE

      // Reset state
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rstCmdReady",  {31'd0, cmdReady}, 32'd0);
      chk("rstWrValid",   {31'd0, wrValid},  32'd0);
      chk("rstWrAddr",    {22'd0, wrAddr},   32'd0);
      chk("rstWrData",    wrData,            32'd0);
      chk("rstBusy",      {31'd0, busy},     32'd0);
      chk("rstDone",      {31'd0, done},     32'd0);
      chk("rstInsnCount", {21'd0, insnCount}, 32'd0);
`ifdef INSN_ENCODER_CHECK_EN
      chk("rstCmdError",  {31'd0, cmdError}, 32'd0);
`endif

      // Single ADD: word visible the cycle after acceptance
      startSession(10'h010);
      @(negedge clk);
      chk("busyInRun", {31'd0, busy}, 32'd1);
      sendVec(0, 1'b1);
      @(negedge clk);
      chk("latencyWrValid", {31'd0, wrValid}, 32'd1);
      chk("latencyWrData",  wrData, 32'h00221820);
      chk("latencyWrAddr",  {22'd0, wrAddr}, 32'h010);
      waitDone(11'd1);
      chk("singleWriteCount", 32'(gotAddr.size()), 32'd1);
      checkWrite(0, 10'h010, 32'h00221820);

      // Every mnemonic from the table in one session
      startSession(10'h100);
      for (int i = 0; i < 14; i++) sendVec(i, (i == 13));
      waitDone(11'd14);
      chk("tableWriteCount", 32'(gotAddr.size()), 32'd14);
      for (int i = 0; i < 14; i++) checkWrite(i, 10'h100 + 10'(i), tbl[i].exp);

      // Backpressure: four accepts fill the FIFO, head holds steady
      wrReady = 1'b0;
      startSession(10'h020);
      for (int i = 0; i < 4; i++) sendVec(i, 1'b0);
      @(negedge clk);
      chk("fullCmdReady", {31'd0, cmdReady}, 32'd0);
      chk("fullWrValid",  {31'd0, wrValid},  32'd1);
      chk("fullWrAddr",   {22'd0, wrAddr},   32'h020);
      chk("fullWrData",   wrData,            tbl[0].exp);
      repeat (3) @(negedge clk);
      chk("stallWrAddr",  {22'd0, wrAddr},   32'h020);
      chk("stallWrData",  wrData,            tbl[0].exp);
      chk("stallCmdReady", {31'd0, cmdReady}, 32'd0);
      @(posedge clk); #1 wrReady = 1'b1;
      sendVec(4, 1'b0);
      sendVec(5, 1'b1);
      waitDone(11'd6);
      chk("bpWriteCount", 32'(gotAddr.size()), 32'd6);
      for (int i = 0; i < 6; i++) checkWrite(i, 10'h020 + 10'(i), tbl[i].exp);

      // Address wrap at the top of the address space
      startSession(10'h3FE);
      for (int i = 0; i < 3; i++) sendVec(i + 6, (i == 2));
      waitDone(11'd3);
      checkWrite(0, 10'h3FE, tbl[6].exp);
      checkWrite(1, 10'h3FF, tbl[7].exp);
      checkWrite(2, 10'h000, tbl[8].exp);

      // Reset with three buffered words discards them
      wrReady = 1'b0;
      startSession(10'h200);
      for (int i = 0; i < 3; i++) sendVec(i, 1'b0);
      @(negedge clk);
      chk("preRstWrValid", {31'd0, wrValid}, 32'd1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("midRstWrValid",   {31'd0, wrValid},  32'd0);
      chk("midRstBusy",      {31'd0, busy},     32'd0);
      chk("midRstInsnCount", {21'd0, insnCount}, 32'd0);
      chk("midRstWrAddr",    {22'd0, wrAddr},   32'd0);
      wrReady = 1'b1;
      repeat (10) @(negedge clk);
      chk("noWriteAfterRst", 32'(gotAddr.size()), 32'd0);

`ifdef INSN_ENCODER_CHECK_EN
      // Illegal mnemonic and shift with nonzero srcB are dropped and flagged
      errPulses = 0;
      startSession(10'h050);
      sendVec(0, 1'b0);
      sendRaw(4'd15, 5'd9, 5'd9, 5'd9, 5'd9, 16'h5555, 1'b0);
      sendRaw(4'd0, 5'd1, 5'd1, 5'd3, 5'd2, 16'h0000, 1'b0);
      sendVec(6, 1'b1);
      waitDone(11'd2);
      chk("errPulses", 32'(errPulses), 32'd2);
      chk("checkWriteCount", 32'(gotAddr.size()), 32'd2);
      checkWrite(0, 10'h050, tbl[0].exp);
      checkWrite(1, 10'h051, tbl[6].exp);
      // An illegal command carrying cmdLast still ends the session
      errPulses = 0;
      startSession(10'h060);
      sendVec(1, 1'b0);
      sendRaw(4'd14, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0000, 1'b1);
      waitDone(11'd1);
      chk("errPulsesLast", 32'(errPulses), 32'd1);
      chk("illegalLastWriteCount", 32'(gotAddr.size()), 32'd1);
      checkWrite(0, 10'h060, tbl[1].exp);
`else
      // Illegal mnemonic encodes as an all-zero word and is written
      startSession(10'h040);
      sendVec(2, 1'b0);
      sendRaw(4'd14, 5'd9, 5'd9, 5'd9, 5'd9, 16'h5555, 1'b1);
      waitDone(11'd2);
      chk("illegalWriteCount", 32'(gotAddr.size()), 32'd2);
      checkWrite(0, 10'h040, tbl[2].exp);
      checkWrite(1, 10'h041, 32'h00000000);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/insn_encoder.md
Name: insn_encoder

Overview:
- Inverse of the instruction decoder: converts a stream of symbolic instruction commands (mnemonic code plus register/immediate operands) into 32-bit instruction words in the decoder's field format.
- Encoded words are buffered in a small FIFO and written sequentially into instruction memory through a valid/ready write port with an auto-incrementing address.
- Used as the program loader in front of IMem, and as a stimulus generator for the core bench.

Parameters:
- FIFO_DEPTH, 4, number of encoded-word buffer entries; power of two, at least 2.
- ADDR_WIDTH, 10, word-address width of the IMem write port.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse; begins a load session at address baseAddr
- baseAddr  in  ADDR_WIDTH  first word address of the session
- cmdValid  in  1  command present
- cmdReady  out  1  command accepted this cycle when cmdValid && cmdReady
- cmdLast  in  1  marks the final command of the session
- cmdMnem  in  4  mnemonic: 0 SLL, 1 SRL, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 SLT, 7 ADDI, 8 ANDI, 9 ORI, 10 LD, 11 ST, 12 BEQ, 13 BNE, 14–15 illegal
- cmdDst  in  5  destination register
- cmdSrcA  in  5  first source register (base register for LD/ST)
- cmdSrcB  in  5  second source register (store data for ST)
- cmdShamt  in  5  shift amount
- cmdImm  in  16  constant field
- wrValid  out  1  IMem write request
- wrReady  in  1  IMem accepts the write when wrValid && wrReady
- wrAddr  out  ADDR_WIDTH  IMem word address
- wrData  out  32  encoded instruction word
- busy  out  1  session active
- done  out  1  one-cycle pulse at end of session
- insnCount  out  ADDR_WIDTH+1  words written in the current or most recent session

Behaviour:
- Field layout: op[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0]; the constant occupies [15:0].
- Opcodes: ALU 0x00, BEQ 0x04, BNE 0x05, ADDI 0x08, ANDI 0x0C, ORI 0x0D, LD 0x23, ST 0x2B.
- Funct codes: SLL 0x00, SRL 0x02, ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A.
- Operand mapping:
  - ADD/SUB/AND/OR/SLT: rs=SrcA, rt=SrcB, rd=Dst, shamt=0.
  - SLL/SRL: rs=0, rt=SrcA, rd=Dst, shamt=Shamt.
  - ADDI/ANDI/ORI/LD: rs=SrcA, rt=Dst, const=Imm.
  - ST/BEQ/BNE: rs=SrcA, rt=SrcB, const=Imm.
  - Operand inputs a mnemonic does not use are ignored.
- Encoding is combinational from the command into the FIFO write side. The word is visible on wrData no earlier than the cycle after acceptance (latency 1 when the FIFO is empty and wrReady=1).
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: cmdReady=0, busy=0. On start: wrAddr←baseAddr, insnCount←0, go to RUN.
  - RUN: cmdReady = FIFO not full (a same-cycle pop does not free a slot). Acceptance with cmdLast=1 moves to DRAIN.
  - DRAIN: cmdReady=0. When the FIFO is empty and no write is pending, go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- start is ignored outside IDLE.
- Output side: wrValid = FIFO not empty; wrData = FIFO head. On each write handshake: pop, wrAddr+1, insnCount+1.
- wrAddr wraps modulo 2^ADDR_WIDTH. insnCount saturates at 2^ADDR_WIDTH.
- Simultaneous push and pop in one cycle are both performed; occupancy is unchanged.
- wrValid, once asserted, holds with stable wrAddr/wrData until the handshake completes.
- Reset values: state IDLE, FIFO empty, cmdReady=0, wrValid=0, wrAddr=0, wrData=0, busy=0, done=0, insnCount=0. Reset mid-session discards all buffered words; no write is issued after reset.

Optional Feature:
- Macro INSN_ENCODER_CHECK_EN.
- Defined:
  - Adds output port cmdError (1 bit, reset 0).
  - Mnemonics 14–15, and shift commands with cmdSrcB≠0, are accepted but not pushed. cmdError pulses for one cycle; insnCount and wrAddr do not advance for that command.
  - An illegal command carrying cmdLast still ends the session.
- Undefined: illegal mnemonics encode as 0x00000000 (SLL r0,r0,0) and are written normally. There is no cmdError port.

Test Plan:
- start with baseAddr=0x010; send ADD Dst3 SrcA1 SrcB2 with cmdLast → one write wrAddr=0x010 wrData=0x00221820, then done pulse, insnCount=1.
- Send ADDI Dst5 SrcA0 Imm7; SLL Dst4 SrcA2 Shamt3; LD Dst6 SrcA1 Imm4; BEQ SrcA1 SrcB2 Imm0xFFFE → writes 0x20050007, 0x000220C0, 0x8C260004, 0x1022FFFE at consecutive addresses.
- Hold wrReady=0 while streaming 6 commands with FIFO_DEPTH=4 → cmdReady drops after 4 accepts; wrAddr/wrData stay stable; releasing wrReady writes all 6 in order.
- baseAddr=0x3FE, three commands → addresses 0x3FE, 0x3FF, 0x000.
- Assert rst with 3 words buffered → next cycle wrValid=0, busy=0, insnCount=0; no further writes.
- CHECK_EN: mnemonic 15 between two ADDs → cmdError pulses once; exactly 2 writes at consecutive addresses; insnCount=2.
